// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern controller: FSM states,
// LFSR tap mask, MISR polynomial and signature width.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    localparam int              LFSR_W    = 8;
    localparam int              SIG_W     = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;

    // Fibonacci step: feedback is the XOR of the tapped bits, shifted in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register: shift with polynomial feedback,
// XOR in the zero-extended response word when enabled, synchronous clear.
module bist_misr
    import bist_pkg::*;
#(
    parameter int N_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] misr_q;
    logic [SIG_W-1:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clr) begin
            misr_d = '0;
        end else if (en) begin
            misr_d = {misr_q[SIG_W-2:0], 1'b0}
                   ^ (misr_q[SIG_W-1] ? MISR_POLY : '0)
                   ^ SIG_W'(din);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig = misr_q;

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST run controller: LFSR pattern source, MISR compactor and IDLE/INIT/RUN/DONE FSM.
// Define BIST_SIG_OUT_EN to export the final signature on port SIG.
module bist_pattern_ctrl
    import bist_pkg::*;
#(
    parameter int                N_IN     = 4,
    parameter int                N_OUT    = 1,
    parameter int                INIT_CYC = 4,
    parameter int                PATTERNS = 255,
    parameter logic [LFSR_W-1:0] SEED     = 8'h01,
    parameter logic [SIG_W-1:0]  GOLDEN   = 16'h0000
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             START,
    output logic [N_IN-1:0]  PI,
    input  logic [N_OUT-1:0] PO,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
`ifdef BIST_SIG_OUT_EN
    output logic [SIG_W-1:0] SIG,
`endif
    output bist_state_e      STATE_DBG
);

    localparam int CNT_MAX = (INIT_CYC > PATTERNS) ? INIT_CYC : PATTERNS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    bist_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [N_IN-1:0]   pi_q, pi_d;
    logic              misr_clr;
    logic              misr_en;
    logic [SIG_W-1:0]  misr_sig;

    // During RUN, lfsr_q always holds the pattern currently driven on PI, so the
    // response on PO and the MISR update in the same cycle belong together.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        pi_d     = '0;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d  = ST_INIT;
                    cnt_d    = '0;
                    lfsr_d   = SEED;
                    misr_clr = 1'b1;
                end
            end
            ST_INIT: begin
                if (cnt_q == CNT_W'(INIT_CYC - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    pi_d    = lfsr_q[N_IN-1:0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                misr_en = 1'b1;
                lfsr_d  = lfsr_next(lfsr_q);
                if (cnt_q == CNT_W'(PATTERNS - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    pi_d  = lfsr_d[N_IN-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            pi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            pi_q    <= pi_d;
        end
    end

    bist_misr #(
        .N_OUT (N_OUT)
    ) u_misr (
        .clk   (CK),
        .rst_n (RN),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   (PO),
        .sig   (misr_sig)
    );

    assign PI        = pi_q;
    assign BUSY      = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign DONE      = (state_q == ST_DONE);
    assign PASS      = DONE && (misr_sig == GOLDEN);
    assign STATE_DBG = state_q;
`ifdef BIST_SIG_OUT_EN
    assign SIG       = DONE ? misr_sig : '0;
`endif

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Bench for bist_pattern_ctrl: three instances (PO tied 0, PO tied 1 with one
// pattern, PO from a small sequential benchmark) checked against a timeline model.
module tb_bist_pattern_ctrl;
    import bist_pkg::*;

    localparam int INIT_N = 4;

    // ---------------- model helpers, written from the polynomial definitions
    function automatic logic [7:0] m_lfsr(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] m, input logic po);
        logic [15:0] r;
        r = {m[14:0], 1'b0};
        if (m[15]) r = r ^ 16'h1021;
        r[0] = r[0] ^ po;
        return r;
    endfunction

    // Benchmark netlist: one flip-flop, 4 inputs, 1 output.
    function automatic logic bench_out(input logic [3:0] p, input logic s);
        return p[3] ^ s ^ (p[1] & p[2]);
    endfunction

    function automatic logic bench_next(input logic [3:0] p, input logic s);
        return (p[0] ^ p[2]) | (s & p[1]);
    endfunction

    // mode 0: PO tied 0, mode 1: PO tied 1, otherwise PO from the benchmark
    function automatic logic [15:0] model_sig(input int mode, input int npat);
        logic [7:0]  l;
        logic [15:0] m;
        logic        s;
        logic        po;
        l = 8'h01;
        m = 16'h0000;
        s = 1'b0;
        for (int i = 0; i < npat; i++) begin
            if (mode == 0)      po = 1'b0;
            else if (mode == 1) po = 1'b1;
            else                po = bench_out(l[3:0], s);
            m = m_misr(m, po);
            s = bench_next(l[3:0], s);
            l = m_lfsr(l);
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD_C = model_sig(2, 255);

    // ---------------- clock / reset
    logic CK = 1'b0;
    logic RN;
    always #5 CK = ~CK;

    // ---------------- DUT wiring
    logic [2:0]  start_v;
    logic [3:0]  pi_v   [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic        pass_v [3];
    bist_state_e st_v   [3];
    logic [0:0]  po_a;
    logic [0:0]  po_b;
    logic [0:0]  po_c;
    logic        s_c;
`ifdef BIST_SIG_OUT_EN
    logic [15:0] sig_v  [3];
`endif

    assign po_a = 1'b0;
    assign po_b = 1'b1;
    assign po_c = bench_out(pi_v[2], s_c);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) s_c <= 1'b0;
        else     s_c <= bench_next(pi_v[2], s_c);
    end

    bist_pattern_ctrl #(.N_IN(4), .N_OUT(1), .INIT_CYC(INIT_N), .PATTERNS(255),
                        .SEED(8'h01), .GOLDEN(16'h0000)) u_a (
        .CK(CK), .RN(RN), .START(start_v[0]), .PI(pi_v[0]), .PO(po_a),
        .BUSY(busy_v[0]), .DONE(done_v[0]), .PASS(pass_v[0]),
`ifdef BIST_SIG_OUT_EN
        .SIG(sig_v[0]),
`endif
        .STATE_DBG(st_v[0]));

    bist_pattern_ctrl #(.N_IN(4), .N_OUT(1), .INIT_CYC(INIT_N), .PATTERNS(1),
                        .SEED(8'h01), .GOLDEN(16'h0000)) u_b (
        .CK(CK), .RN(RN), .START(start_v[1]), .PI(pi_v[1]), .PO(po_b),
        .BUSY(busy_v[1]), .DONE(done_v[1]), .PASS(pass_v[1]),
`ifdef BIST_SIG_OUT_EN
        .SIG(sig_v[1]),
`endif
        .STATE_DBG(st_v[1]));

    bist_pattern_ctrl #(.N_IN(4), .N_OUT(1), .INIT_CYC(INIT_N), .PATTERNS(255),
                        .SEED(8'h01), .GOLDEN(GOLD_C)) u_c (
        .CK(CK), .RN(RN), .START(start_v[2]), .PI(pi_v[2]), .PO(po_c),
        .BUSY(busy_v[2]), .DONE(done_v[2]), .PASS(pass_v[2]),
`ifdef BIST_SIG_OUT_EN
        .SIG(sig_v[2]),
`endif
        .STATE_DBG(st_v[2]));

    // ---------------- scoreboard counters and check task
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model
    // t = number of edges since the accepted START (that edge counts as 1);
    // 0 means never started, LAST means results are being held.
    int          patt_n  [3] = '{255, 1, 255};
    logic [15:0] golden_v[3];
    logic [15:0] exp_sig [3];
    logic [7:0]  pat     [255];
    int          t       [3];
    logic        chk_en  = 1'b0;

    always @(posedge CK or negedge RN) begin
        for (int i = 0; i < 3; i++) begin
            if (!RN) begin
                t[i] <= 0;
            end else if ((t[i] == 0 || t[i] == INIT_N + patt_n[i] + 1) && start_v[i]) begin
                t[i] <= 1;
            end else if (t[i] != 0 && t[i] != INIT_N + patt_n[i] + 1) begin
                t[i] <= t[i] + 1;
            end
        end
    end

    // ---------------- compare process
    always @(negedge CK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                int   last;
                logic e_busy, e_done, e_pass;
                logic [3:0] e_pi;
                last   = INIT_N + patt_n[i] + 1;
                e_busy = RN && (t[i] >= 1) && (t[i] < last);
                e_done = RN && (t[i] == last);
                e_pass = e_done && (exp_sig[i] == golden_v[i]);
                e_pi   = (RN && t[i] > INIT_N && t[i] < last) ? pat[t[i] - INIT_N - 1][3:0] : 4'h0;
                check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(e_busy));
                check($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(e_done));
                check($sformatf("pass[%0d]", i), 32'(pass_v[i]), 32'(e_pass));
                check($sformatf("pi[%0d]", i),   32'(pi_v[i]),   32'(e_pi));
`ifdef BIST_SIG_OUT_EN
                check($sformatf("sig[%0d]", i),  32'(sig_v[i]),  32'(e_done ? exp_sig[i] : 16'h0));
`endif
            end
        end
    end

    // ---------------- directed stimulus
    logic [3:0] lit_pi [5];

    initial begin
        logic [7:0] l;
        RN      = 1'b0;
        start_v = 3'b000;
        lit_pi  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

        l = 8'h01;
        for (int i = 0; i < 255; i++) begin
            pat[i] = l;
            l      = m_lfsr(l);
        end
        exp_sig[0]  = model_sig(0, 255);
        exp_sig[1]  = model_sig(1, 1);
        exp_sig[2]  = GOLD_C;
        golden_v[0] = 16'h0000;
        golden_v[1] = 16'h0000;
        golden_v[2] = GOLD_C;

        // hand-computed values that pin the model
        check("model_pat0", 32'(pat[0]), 32'h01);
        check("model_pat3", 32'(pat[3]), 32'h08);
        check("model_pat4", 32'(pat[4]), 32'h11);
        check("model_sig_tie0", 32'(exp_sig[0]), 32'h0000);
        check("model_sig_tie1_1", 32'(exp_sig[1]), 32'h0001);
        check("model_sig_tie1_2", 32'(model_sig(1, 2)), 32'h0003);
        check("model_sig_tie1_17", 32'(model_sig(1, 17)), 32'hEFDE);

        // reset state
        repeat (3) @(negedge CK);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy_v[0]), 32'h0);
        check("rst_done", 32'(done_v[0]), 32'h0);
        check("rst_pass", 32'(pass_v[0]), 32'h0);
        check("rst_pi",   32'(pi_v[0]),   32'h0);
        check("rst_state", 32'(st_v[0]),  32'(ST_IDLE));
        @(negedge CK);
        #2 RN = 1'b1;
        repeat (2) @(negedge CK);

        // run 1: all three instances started on the same edge
        start_v = 3'b111;
        @(negedge CK);
        for (int n = 1; n <= 262; n++) begin
            start_v = 3'b000;
            if (n <= 4) begin
                check("init_pi", 32'(pi_v[0]), 32'h0);
                check("init_busy", 32'(busy_v[0]), 32'h1);
            end
            if (n >= 5 && n <= 9) check($sformatf("run_pi_%0d", n - 4), 32'(pi_v[0]), 32'(lit_pi[n - 5]));
            if (n == 5) check("b_not_done", 32'(done_v[1]), 32'h0);
            if (n == 6) begin
                check("b_done", 32'(done_v[1]), 32'h1);
                check("b_pass", 32'(pass_v[1]), 32'h0);
`ifdef BIST_SIG_OUT_EN
                check("b_sig", 32'(sig_v[1]), 32'h0001);
`endif
            end
            if (n == 259) check("a_done_early", 32'(done_v[0]), 32'h0);
            if (n == 260) begin
                check("a_done_260", 32'(done_v[0]), 32'h1);
                check("a_pass",     32'(pass_v[0]), 32'h1);
                check("c_done_260", 32'(done_v[2]), 32'h1);
                check("c_pass",     32'(pass_v[2]), 32'h1);
            end
            @(negedge CK);
        end

        // run 2: reset asserted in the middle of RUN
        start_v = 3'b101;
        @(negedge CK);
        start_v = 3'b000;
        repeat (100) @(negedge CK);
        #2 RN = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy_v[0]), 32'h0);
        check("mid_rst_pi",    32'(pi_v[2]),   32'h0);
        check("mid_rst_state", 32'(st_v[2]),   32'(ST_IDLE));
        check("mid_rst_done",  32'(done_v[2]), 32'h0);
        @(negedge CK);
        #2 RN = 1'b1;
        @(negedge CK);

        // run 3: START held high on c through RUN, then a normal run on a
        start_v = 3'b101;
        @(negedge CK);
        for (int n = 1; n <= 560; n++) begin
            start_v[0] = 1'b0;
            if (n == 265) start_v[2] = 1'b0;
            if (n == 150) begin
                check("held_busy", 32'(busy_v[2]), 32'h1);
                check("held_no_done", 32'(done_v[2]), 32'h0);
            end
            if (n == 260) begin
                check("held_done", 32'(done_v[2]), 32'h1);
                check("held_pass", 32'(pass_v[2]), 32'h1);
                check("a_done_after_rst", 32'(done_v[0]), 32'h1);
            end
            if (n == 261) check("held_restart", 32'(busy_v[2]), 32'h1);
            if (n == 520) begin
                check("restart_done", 32'(done_v[2]), 32'h1);
                check("restart_pass", 32'(pass_v[2]), 32'h1);
            end
            @(negedge CK);
        end
        check("final_c_done", 32'(done_v[2]), 32'h1);
        check("final_a_pass", 32'(pass_v[0]), 32'h1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
